// File: rtl/instr_sequencer_pkg.sv
// Shared symbols for the instruction sequencer: state codes driven to the
// control-signal decoder, opcode constants, the micro-op ROM entry payload
// and the sequencer's internal phase encoding.
package instr_sequencer_pkg;

    localparam int unsigned SEQ_STATE_W = 8;
    localparam int unsigned SEQ_OPC_W   = 4;
    localparam int unsigned SEQ_STEP_W  = 3;

    typedef logic [SEQ_STATE_W-1:0] state_code_t;
    typedef logic [SEQ_OPC_W-1:0]   opc_t;
    typedef logic [SEQ_STEP_W-1:0]  step_t;

    // State codes; IDLE and DECODE map to no strobes in the control decoder.
    localparam state_code_t STATE_IDLE       = 8'h00;
    localparam state_code_t STATE_FETCH_PC   = 8'h01;
    localparam state_code_t STATE_FETCH_INST = 8'h02;
    localparam state_code_t STATE_DECODE     = 8'h03;
    localparam state_code_t STATE_ALU_EXEC   = 8'h04;
    localparam state_code_t STATE_ALU_OUT    = 8'h05;
    localparam state_code_t STATE_MOVE_REG   = 8'h06;
    localparam state_code_t STATE_SET_REG    = 8'h07;
    localparam state_code_t STATE_LOAD_ADDR  = 8'h08;
    localparam state_code_t STATE_SET_MEM    = 8'h09;
    localparam state_code_t STATE_FETCH_SP   = 8'h0A;
    localparam state_code_t STATE_STACK_REG  = 8'h0B;
    localparam state_code_t STATE_INC_SP     = 8'h0C;
    localparam state_code_t STATE_JUMP       = 8'h0D;
    localparam state_code_t STATE_STORE_PC   = 8'h0E;
    localparam state_code_t STATE_TMP_JUMP   = 8'h0F;
    localparam state_code_t STATE_RET        = 8'h10;
    localparam state_code_t STATE_MOUT_STORE = 8'h11;
    localparam state_code_t STATE_ROUT_STORE = 8'h12;
    localparam state_code_t STATE_HALT       = 8'h13;

    localparam opc_t OPC_NOP  = 4'd0;
    localparam opc_t OPC_ALU  = 4'd1;
    localparam opc_t OPC_MOV  = 4'd2;
    localparam opc_t OPC_SET  = 4'd3;
    localparam opc_t OPC_STM  = 4'd4;
    localparam opc_t OPC_LDM  = 4'd5;
    localparam opc_t OPC_PUSH = 4'd6;
    localparam opc_t OPC_POP  = 4'd7;
    localparam opc_t OPC_JMP  = 4'd8;
    localparam opc_t OPC_CALL = 4'd9;
    localparam opc_t OPC_RET  = 4'd10;
    localparam opc_t OPC_MOUT = 4'd11;
    localparam opc_t OPC_ROUT = 4'd12;
    localparam opc_t OPC_U13  = 4'd13;
    localparam opc_t OPC_U14  = 4'd14;
    localparam opc_t OPC_HALT = 4'd15;

    // One micro-op ROM lookup: state to enter and whether it ends the instruction.
    typedef struct packed {
        state_code_t code;
        logic        last;
    } rom_entry_t;

    // Internal phase; needed because FETCH_PC also appears as a micro-op.
    typedef enum logic [2:0] {
        PH_IDLE,
        PH_FETCH_PC,
        PH_FETCH_INST,
        PH_DECODE,
        PH_UOP,
        PH_HALT
    } phase_t;

    function automatic logic opc_is_illegal(input opc_t opc);
        return (opc == OPC_U13) || (opc == OPC_U14);
    endfunction

    // Opcodes with no micro-ops finish in DECODE.
    function automatic logic opc_is_empty(input opc_t opc);
        return (opc == OPC_NOP) || opc_is_illegal(opc);
    endfunction

endpackage

// File: rtl/instr_sequencer_seq_rom.sv
// Micro-op table: combinational (opcode, step) -> {state code, last flag}.
// Ports:
//   opcode  - latched (or decoding) opcode
//   step    - zero-based micro-op index
//   entry_c - state code of that micro-op and whether it is the final one;
//             an index past the end of the sequence (or an empty sequence)
//             returns FETCH_PC with last set.
module instr_sequencer_seq_rom
    import instr_sequencer_pkg::*;
(
    input  logic [SEQ_OPC_W-1:0]  opcode,
    input  logic [SEQ_STEP_W-1:0] step,
    output rom_entry_t            entry_c
);

    state_code_t uop0;
    state_code_t uop1;
    state_code_t uop2;
    logic [1:0]  len;
    step_t       len_w;

    // Per-opcode micro-op list
    always_comb begin
        uop0 = STATE_FETCH_PC;
        uop1 = STATE_FETCH_PC;
        uop2 = STATE_FETCH_PC;
        len  = 2'd0;
        case (opcode)
            OPC_ALU:  begin uop0 = STATE_ALU_EXEC;   uop1 = STATE_ALU_OUT;                               len = 2'd2; end
            OPC_MOV:  begin uop0 = STATE_MOVE_REG;                                                       len = 2'd1; end
            OPC_SET:  begin uop0 = STATE_FETCH_PC;   uop1 = STATE_SET_REG;                               len = 2'd2; end
            OPC_STM:  begin uop0 = STATE_FETCH_PC;   uop1 = STATE_LOAD_ADDR; uop2 = STATE_SET_MEM;       len = 2'd3; end
            OPC_LDM:  begin uop0 = STATE_FETCH_PC;   uop1 = STATE_LOAD_ADDR; uop2 = STATE_SET_REG;       len = 2'd3; end
            OPC_PUSH: begin uop0 = STATE_FETCH_SP;   uop1 = STATE_STACK_REG;                             len = 2'd2; end
            OPC_POP:  begin uop0 = STATE_INC_SP;     uop1 = STATE_FETCH_SP;  uop2 = STATE_SET_REG;       len = 2'd3; end
            OPC_JMP:  begin uop0 = STATE_FETCH_PC;   uop1 = STATE_JUMP;                                  len = 2'd2; end
            OPC_CALL: begin uop0 = STATE_FETCH_SP;   uop1 = STATE_STORE_PC;  uop2 = STATE_TMP_JUMP;      len = 2'd3; end
            OPC_RET:  begin uop0 = STATE_INC_SP;     uop1 = STATE_FETCH_SP;  uop2 = STATE_RET;           len = 2'd3; end
            OPC_MOUT: begin uop0 = STATE_FETCH_PC;   uop1 = STATE_LOAD_ADDR; uop2 = STATE_MOUT_STORE;    len = 2'd3; end
            OPC_ROUT: begin uop0 = STATE_ROUT_STORE;                                                     len = 2'd1; end
            OPC_HALT: begin uop0 = STATE_HALT;                                                           len = 2'd1; end
            default:  len = 2'd0;
        endcase
    end

    assign len_w = SEQ_STEP_W'(len);

    // Select the indexed micro-op
    always_comb begin
        entry_c.code = STATE_FETCH_PC;
        entry_c.last = 1'b1;
        if (step < len_w) begin
            case (step)
                3'd0:    entry_c.code = uop0;
                3'd1:    entry_c.code = uop1;
                default: entry_c.code = uop2;
            endcase
            entry_c.last = (step == SEQ_STEP_W'(len_w - SEQ_STEP_W'(1)));
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: steps the CPU through FETCH_PC, FETCH_INST, DECODE
// and the per-opcode micro-op sequence, stalling on the I/O handshake.
// Optional feature macro: INSTR_SEQ_SINGLE_STEP_EN (adds step_req; the FSM
// parks in IDLE before every fetch until a rising edge of step_req).
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   opcode      - instruction register opcode field
//   io_ack      - I/O acknowledge for MOUT_STORE / ROUT_STORE
//   step_req    - single-step request (only with INSTR_SEQ_SINGLE_STEP_EN)
//   state       - registered state code for the control decoder
//   halted      - high while in HALT
//   illegal     - one-cycle pulse in DECODE of an undefined opcode
//   instr_done  - one-cycle pulse on entry to the last micro-op of an
//                 instruction (DECODE for empty sequences)
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int unsigned STATE_W = 8,
    parameter int unsigned OPC_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OPC_W-1:0]   opcode,
    input  logic               io_ack,
`ifdef INSTR_SEQ_SINGLE_STEP_EN
    input  logic               step_req,
`endif
    output logic [STATE_W-1:0] state,
    output logic               halted,
    output logic               illegal,
    output logic               instr_done
);

`ifdef INSTR_SEQ_SINGLE_STEP_EN
    localparam phase_t      PH_RETIRE    = PH_IDLE;
    localparam state_code_t STATE_RETIRE = STATE_IDLE;
`else
    localparam phase_t      PH_RETIRE    = PH_FETCH_PC;
    localparam state_code_t STATE_RETIRE = STATE_FETCH_PC;
`endif

    phase_t      phase_q, phase_d;
    state_code_t state_q, state_d;
    opc_t        opc_q, opc_d;
    step_t       step_q, step_d;
    logic        last_q, last_d;
    logic        halted_d, illegal_d, done_d;

    opc_t        opc_in;
    opc_t        rom_opc;
    step_t       rom_step;
    rom_entry_t  rom_entry;
    logic        load_uop;
    logic        io_wait;
    logic        fetch_go;

    assign opc_in  = SEQ_OPC_W'(opcode);
    assign io_wait = ((state_q == STATE_MOUT_STORE) || (state_q == STATE_ROUT_STORE)) && !io_ack;

`ifdef INSTR_SEQ_SINGLE_STEP_EN
    logic step_req_q;

    // Registered copy of step_req for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_req_q <= 1'b0;
        end else begin
            step_req_q <= step_req;
        end
    end

    assign fetch_go = step_req && !step_req_q;
`else
    assign fetch_go = 1'b1;
`endif

    instr_sequencer_seq_rom u_seq_rom (
        .opcode  (rom_opc),
        .step    (rom_step),
        .entry_c (rom_entry)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q    <= PH_IDLE;
            state_q    <= STATE_IDLE;
            opc_q      <= OPC_NOP;
            step_q     <= '0;
            last_q     <= 1'b0;
            halted     <= 1'b0;
            illegal    <= 1'b0;
            instr_done <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            state_q    <= state_d;
            opc_q      <= opc_d;
            step_q     <= step_d;
            last_q     <= last_d;
            halted     <= halted_d;
            illegal    <= illegal_d;
            instr_done <= done_d;
        end
    end

    assign state = STATE_W'(state_q);

    // Next-state and output logic
    always_comb begin
        phase_d   = phase_q;
        state_d   = state_q;
        opc_d     = opc_q;
        step_d    = step_q;
        last_d    = last_q;
        halted_d  = halted;
        illegal_d = 1'b0;
        done_d    = 1'b0;
        rom_opc   = opc_q;
        rom_step  = SEQ_STEP_W'(step_q + SEQ_STEP_W'(1));
        load_uop  = 1'b0;

        case (phase_q)
            PH_IDLE: begin
                if (fetch_go) begin
                    phase_d = PH_FETCH_PC;
                    state_d = STATE_FETCH_PC;
                end
            end
            PH_FETCH_PC: begin
                phase_d = PH_FETCH_INST;
                state_d = STATE_FETCH_INST;
            end
            PH_FETCH_INST: begin
                // DECODE-cycle flags are registered here; opcode is already stable.
                phase_d   = PH_DECODE;
                state_d   = STATE_DECODE;
                illegal_d = opc_is_illegal(opc_in);
                done_d    = opc_is_empty(opc_in);
            end
            PH_DECODE: begin
                opc_d    = opc_in;
                step_d   = '0;
                rom_opc  = opc_in;
                rom_step = '0;
                if (opc_is_empty(opc_in)) begin
                    phase_d = PH_RETIRE;
                    state_d = STATE_RETIRE;
                end else begin
                    load_uop = 1'b1;
                end
            end
            PH_UOP: begin
                if (io_wait) begin
                    phase_d = PH_UOP;
                end else if (last_q) begin
                    phase_d = PH_RETIRE;
                    state_d = STATE_RETIRE;
                    step_d  = '0;
                end else begin
                    step_d   = SEQ_STEP_W'(step_q + SEQ_STEP_W'(1));
                    load_uop = 1'b1;
                end
            end
            PH_HALT: begin
                phase_d = PH_HALT;
            end
            default: begin
                phase_d = PH_IDLE;
                state_d = STATE_IDLE;
            end
        endcase

        // Enter the micro-op the ROM selected; HALT is terminal.
        if (load_uop) begin
            state_d = rom_entry.code;
            last_d  = rom_entry.last;
            done_d  = rom_entry.last;
            if (rom_entry.code == STATE_HALT) begin
                phase_d  = PH_HALT;
                halted_d = 1'b1;
            end else begin
                phase_d = PH_UOP;
            end
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed testbench for instr_sequencer (default build and, when
// INSTR_SEQ_SINGLE_STEP_EN is defined, the single-step variant).
module tb_instr_sequencer;

    localparam logic [7:0] S_IDLE  = 8'h00;
    localparam logic [7:0] S_FPC   = 8'h01;
    localparam logic [7:0] S_FINST = 8'h02;
    localparam logic [7:0] S_DEC   = 8'h03;
    localparam logic [7:0] S_ALUX  = 8'h04;
    localparam logic [7:0] S_ALUO  = 8'h05;
    localparam logic [7:0] S_MOV   = 8'h06;
    localparam logic [7:0] S_SETR  = 8'h07;
    localparam logic [7:0] S_LDA   = 8'h08;
    localparam logic [7:0] S_SETM  = 8'h09;
    localparam logic [7:0] S_FSP   = 8'h0A;
    localparam logic [7:0] S_STK   = 8'h0B;
    localparam logic [7:0] S_INCSP = 8'h0C;
    localparam logic [7:0] S_JMP   = 8'h0D;
    localparam logic [7:0] S_STPC  = 8'h0E;
    localparam logic [7:0] S_TJMP  = 8'h0F;
    localparam logic [7:0] S_RET   = 8'h10;
    localparam logic [7:0] S_MOUT  = 8'h11;
    localparam logic [7:0] S_ROUT  = 8'h12;
    localparam logic [7:0] S_HALT  = 8'h13;

    logic       clk;
    logic       rst_n;
    logic [3:0] opcode;
    logic       io_ack;
    logic [7:0] state;
    logic       halted;
    logic       illegal;
    logic       instr_done;
`ifdef INSTR_SEQ_SINGLE_STEP_EN
    logic       step_req;
`endif

    int checks;
    int failures;

    instr_sequencer #(
        .STATE_W (8),
        .OPC_W   (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .io_ack     (io_ack),
`ifdef INSTR_SEQ_SINGLE_STEP_EN
        .step_req   (step_req),
`endif
        .state      (state),
        .halted     (halted),
        .illegal    (illegal),
        .instr_done (instr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n  = 1'b0;
        opcode = 4'd0;
        io_ack = 1'b0;
        #12;
        checks++;
        if (state !== S_IDLE || halted !== 1'b0 || illegal !== 1'b0 || instr_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: state=%h halted=%b illegal=%b done=%b expected state=%h all flags 0",
                     state, halted, illegal, instr_done, S_IDLE);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
`ifdef INSTR_SEQ_SINGLE_STEP_EN
        if (state !== S_IDLE) begin
            failures++;
            $display("FAIL reset_release: state=%h expected=%h", state, S_IDLE);
        end
`else
        if (state !== S_FPC) begin
            failures++;
            $display("FAIL reset_release: state=%h expected=%h", state, S_FPC);
        end
`endif
    endtask

    // Runs one instruction from a sampled FETCH_PC through to the next FETCH_PC.
    task automatic test_instr(input logic [3:0] opc, input logic [7:0] u0, input logic [7:0] u1,
                              input logic [7:0] u2, input int n, input logic ack, input string name);
        logic [7:0] uops  [0:2];
        logic [7:0] exp_s [0:5];
        logic       exp_d [0:5];
        logic       exp_i [0:5];
        uops[0] = u0;
        uops[1] = u1;
        uops[2] = u2;
        exp_s[0] = S_FINST; exp_d[0] = 1'b0;       exp_i[0] = 1'b0;
        exp_s[1] = S_DEC;   exp_d[1] = (n == 0);   exp_i[1] = (opc == 4'd13) || (opc == 4'd14);
        for (int k = 0; k < n; k++) begin
            exp_s[2+k] = uops[k];
            exp_d[2+k] = (k == n - 1);
            exp_i[2+k] = 1'b0;
        end
        exp_s[2+n] = S_FPC; exp_d[2+n] = 1'b0; exp_i[2+n] = 1'b0;
        opcode = opc;
        io_ack = ack;
        for (int k = 0; k < 3 + n; k++) begin
            tick();
            checks++;
            if (state !== exp_s[k] || instr_done !== exp_d[k] || illegal !== exp_i[k] || halted !== 1'b0) begin
                failures++;
                $display("FAIL %s cyc%0d: state=%h done=%b illegal=%b halted=%b expected state=%h done=%b illegal=%b halted=0",
                         name, k, state, instr_done, illegal, halted, exp_s[k], exp_d[k], exp_i[k]);
            end
        end
        io_ack = 1'b0;
    endtask

    task automatic test_mout_wait;
        logic [7:0] pre [0:3];
        int         mout_cycles;
        pre[0] = S_FINST; pre[1] = S_DEC; pre[2] = S_FPC; pre[3] = S_LDA;
        opcode = 4'd11;
        io_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (state !== pre[k]) begin
                failures++;
                $display("FAIL mout_prefix cyc%0d: state=%h expected=%h", k, state, pre[k]);
            end
        end
        mout_cycles = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (state === S_MOUT) mout_cycles++;
            checks++;
            if (state !== S_MOUT || instr_done !== (k == 0)) begin
                failures++;
                $display("FAIL mout_hold cyc%0d: state=%h done=%b expected state=%h done=%b",
                         k, state, instr_done, S_MOUT, (k == 0));
            end
        end
        io_ack = 1'b1;
        tick();
        io_ack = 1'b0;
        checks++;
        if (state !== S_FPC || mout_cycles != 4) begin
            failures++;
            $display("FAIL mout_release: state=%h mout_cycles=%0d expected state=%h mout_cycles=4",
                     state, mout_cycles, S_FPC);
        end
    endtask

    task automatic test_reset_mid_call;
        logic [7:0] pre [0:3];
        pre[0] = S_FINST; pre[1] = S_DEC; pre[2] = S_FSP; pre[3] = S_STPC;
        opcode = 4'd9;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (state !== pre[k]) begin
                failures++;
                $display("FAIL call_prefix cyc%0d: state=%h expected=%h", k, state, pre[k]);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (state !== S_IDLE || instr_done !== 1'b0 || halted !== 1'b0) begin
            failures++;
            $display("FAIL call_async_reset: state=%h done=%b halted=%b expected state=%h flags 0",
                     state, instr_done, halted, S_IDLE);
        end
        opcode = 4'd2;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (state !== S_FPC) begin
            failures++;
            $display("FAIL call_restart: state=%h expected=%h", state, S_FPC);
        end
    endtask

    task automatic test_halt;
        logic [7:0] pre [0:2];
        pre[0] = S_FINST; pre[1] = S_DEC; pre[2] = S_HALT;
        opcode = 4'd15;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (state !== pre[k] || halted !== (k == 2) || instr_done !== (k == 2)) begin
                failures++;
                $display("FAIL halt_entry cyc%0d: state=%h halted=%b done=%b expected state=%h halted=%b done=%b",
                         k, state, halted, instr_done, pre[k], (k == 2), (k == 2));
            end
        end
        for (int k = 0; k < 20; k++) begin
            opcode = 4'($urandom_range(15, 0));
            io_ack = 1'($urandom_range(1, 0));
            tick();
            checks++;
            if (state !== S_HALT || halted !== 1'b1 || instr_done !== 1'b0 || illegal !== 1'b0) begin
                failures++;
                $display("FAIL halt_sticky cyc%0d: state=%h halted=%b done=%b illegal=%b expected state=%h halted=1 done=0 illegal=0",
                         k, state, halted, instr_done, illegal, S_HALT);
            end
        end
        io_ack = 1'b0;
    endtask

`ifdef INSTR_SEQ_SINGLE_STEP_EN
    task automatic test_single_step;
        logic [7:0] seq [0:4];
        int         mov_count;
        seq[0] = S_FPC; seq[1] = S_FINST; seq[2] = S_DEC; seq[3] = S_MOV; seq[4] = S_IDLE;
        opcode    = 4'd2;
        step_req  = 1'b0;
        mov_count = 0;
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 3; k++) begin
                tick();
                checks++;
                if (state !== S_IDLE) begin
                    failures++;
                    $display("FAIL step_wait p%0d cyc%0d: state=%h expected=%h", p, k, state, S_IDLE);
                end
            end
            step_req = 1'b1;
            for (int k = 0; k < 5; k++) begin
                tick();
                if (k == 1) step_req = 1'b0;
                if (state === S_MOV) mov_count++;
                checks++;
                if (state !== seq[k] || instr_done !== (k == 3)) begin
                    failures++;
                    $display("FAIL step_run p%0d cyc%0d: state=%h done=%b expected state=%h done=%b",
                             p, k, state, instr_done, seq[k], (k == 3));
                end
            end
        end
        checks++;
        if (mov_count != 2) begin
            failures++;
            $display("FAIL step_count: move_reg_cycles=%0d expected=2", mov_count);
        end
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
`ifdef INSTR_SEQ_SINGLE_STEP_EN
        step_req = 1'b0;
        test_reset();
        test_single_step();
`else
        test_reset();
        test_instr(4'd1,  S_ALUX,  S_ALUO, S_FPC,  2, 1'b0, "alu");
        test_mout_wait();
        test_instr(4'd13, S_FPC,   S_FPC,  S_FPC,  0, 1'b0, "illegal13");
        test_instr(4'd14, S_FPC,   S_FPC,  S_FPC,  0, 1'b1, "illegal14");
        test_instr(4'd0,  S_FPC,   S_FPC,  S_FPC,  0, 1'b0, "nop");
        test_instr(4'd12, S_ROUT,  S_FPC,  S_FPC,  1, 1'b1, "rout_ack_high");
        test_instr(4'd3,  S_FPC,   S_SETR, S_FPC,  2, 1'b1, "set");
        test_instr(4'd4,  S_FPC,   S_LDA,  S_SETM, 3, 1'b0, "stm");
        test_instr(4'd5,  S_FPC,   S_LDA,  S_SETR, 3, 1'b0, "ldm");
        test_instr(4'd6,  S_FSP,   S_STK,  S_FPC,  2, 1'b0, "push");
        test_instr(4'd7,  S_INCSP, S_FSP,  S_SETR, 3, 1'b0, "pop");
        test_instr(4'd8,  S_FPC,   S_JMP,  S_FPC,  2, 1'b0, "jmp");
        test_instr(4'd10, S_INCSP, S_FSP,  S_RET,  3, 1'b0, "ret");
        test_reset_mid_call();
        test_instr(4'd2,  S_MOV,   S_FPC,  S_FPC,  1, 1'b0, "mov_after_reset");
        test_instr(4'd9,  S_FSP,   S_STPC, S_TJMP, 3, 1'b0, "call");
        test_halt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
